// File: rtl/dcache_mshr_file.sv
// dcache_mshr_file
//   Miss-status holding register file for the data cache. Tracks up to
//   NR_ENTRIES outstanding line misses, merges secondary stores into a line
//   that has not been sent yet, issues memory requests in round-robin order
//   and returns fill data tagged with the original requester ID.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   alloc_*                 miss request from the miss handler (valid/ready)
//   alloc_idx_o             entry allocated or merged into (valid with ready)
//   lookup_addr_i/_hit_o    combinational probe: line held by a busy entry
//   miss_*                  request to the memory side (valid/ready)
//   fill_*                  memory response for one entry
//   rsp_*                   registered completion pulse with ID and data
//   full_o, empty_o         no free entry / every entry free
module dcache_mshr_file #(
  parameter int NR_ENTRIES  = 4,
  parameter int ADDR_WIDTH  = 34,
  parameter int ID_WIDTH    = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int LINE_OFFSET = 3,
  localparam int IDX_W  = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1,
  localparam int BE_W   = DATA_WIDTH / 8,
  localparam int LINE_W = ADDR_WIDTH - LINE_OFFSET
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  input  logic [ADDR_WIDTH-1:0] alloc_addr_i,
  input  logic [ID_WIDTH-1:0]   alloc_id_i,
  input  logic                  alloc_we_i,
  input  logic [DATA_WIDTH-1:0] alloc_wdata_i,
  input  logic [BE_W-1:0]       alloc_be_i,
  output logic [IDX_W-1:0]      alloc_idx_o,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  output logic                  lookup_hit_o,
  output logic                  miss_valid_o,
  input  logic                  miss_ready_i,
  output logic [IDX_W-1:0]      miss_idx_o,
  output logic [ADDR_WIDTH-1:0] miss_addr_o,
  output logic                  miss_we_o,
  output logic [DATA_WIDTH-1:0] miss_wdata_o,
  output logic [BE_W-1:0]       miss_be_o,
  input  logic                  fill_valid_i,
  input  logic [IDX_W-1:0]      fill_idx_i,
  input  logic [DATA_WIDTH-1:0] fill_data_i,
  output logic                  rsp_valid_o,
  output logic [ID_WIDTH-1:0]   rsp_id_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  typedef enum logic [1:0] {IDLE, PENDING, INFLIGHT} entry_state_e;

  entry_state_e            state_q [NR_ENTRIES];
  entry_state_e            state_d [NR_ENTRIES];
  logic [LINE_W-1:0]       line_q  [NR_ENTRIES];
  logic [ID_WIDTH-1:0]     id_q    [NR_ENTRIES];
  logic                    we_q    [NR_ENTRIES];
  logic [DATA_WIDTH-1:0]   wdata_q [NR_ENTRIES];
  logic [BE_W-1:0]         be_q    [NR_ENTRIES];
  logic [IDX_W-1:0]        rr_q;

  logic [LINE_W-1:0] alloc_line, lookup_line;
  logic              match_any, free_any, all_idle;
  logic [IDX_W-1:0]  match_idx, free_idx, issue_idx;
  logic              issue_valid, handshake;
  logic              merge_ok, alloc_ok, do_alloc, do_merge, fill_ok;
  logic              unused_offset_bits;

  assign alloc_line  = alloc_addr_i[ADDR_WIDTH-1:LINE_OFFSET];
  assign lookup_line = lookup_addr_i[ADDR_WIDTH-1:LINE_OFFSET];
  assign unused_offset_bits = ^{alloc_addr_i[LINE_OFFSET-1:0], lookup_addr_i[LINE_OFFSET-1:0]};

  // Address match against busy entries, lowest free entry, occupancy flags.
  // Entries never share a line, so at most one entry can match.
  always_comb begin
    match_any    = 1'b0;
    match_idx    = '0;
    free_any     = 1'b0;
    free_idx     = '0;
    all_idle     = 1'b1;
    lookup_hit_o = 1'b0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      if (state_q[i] != IDLE) begin
        all_idle = 1'b0;
        if (line_q[i] == alloc_line) begin
          match_any = 1'b1;
          match_idx = IDX_W'(i);
        end
        if (line_q[i] == lookup_line) lookup_hit_o = 1'b1;
      end else if (!free_any) begin
        free_any = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign full_o  = !free_any;
  assign empty_o = all_idle;

  // Round-robin pick: first PENDING entry scanning upward from rr with wrap.
  always_comb begin
    int j;
    issue_valid = 1'b0;
    issue_idx   = '0;
    for (int i = 0; i < NR_ENTRIES; i++) begin
      j = int'(rr_q) + i;
      if (j >= NR_ENTRIES) j = j - NR_ENTRIES;
      if (!issue_valid && state_q[j] == PENDING) begin
        issue_valid = 1'b1;
        issue_idx   = IDX_W'(j);
      end
    end
  end

  assign miss_valid_o = issue_valid;
  assign miss_idx_o   = issue_idx;
  assign miss_addr_o  = {line_q[issue_idx], {LINE_OFFSET{1'b0}}};
  assign miss_we_o    = we_q[issue_idx];
  assign miss_wdata_o = wdata_q[issue_idx];
  assign miss_be_o    = be_q[issue_idx];
  assign handshake    = issue_valid && miss_ready_i;

  // Only a store into a store entry that is still waiting can merge; an entry
  // leaving this cycle has already committed its data, so the merge stalls.
  assign merge_ok = match_any && state_q[match_idx] == PENDING && we_q[match_idx]
                    && alloc_we_i && !(handshake && issue_idx == match_idx);
  assign alloc_ok = !match_any && free_any;

  assign alloc_ready_o = !rst_i && alloc_valid_i && (merge_ok || alloc_ok);
  assign alloc_idx_o   = match_any ? match_idx : free_idx;
  assign do_alloc      = alloc_ready_o && alloc_ok;
  assign do_merge      = alloc_ready_o && merge_ok;

  assign fill_ok = fill_valid_i && (int'(fill_idx_i) < NR_ENTRIES)
                   && state_q[fill_idx_i] == INFLIGHT;

  // Per-entry next state. Alloc, issue and fill act on entries in disjoint
  // states, so they never target the same entry in one cycle.
  always_comb begin
    state_d = state_q;
    if (do_alloc)  state_d[free_idx]   = PENDING;
    if (handshake) state_d[issue_idx]  = INFLIGHT;
    if (fill_ok)   state_d[fill_idx_i] = IDLE;
  end

  // State, round-robin pointer and the registered response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) state_q[i] <= IDLE;
      rr_q        <= '0;
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
    end else begin
      state_q <= state_d;
      if (handshake)
        rr_q <= (issue_idx == IDX_W'(NR_ENTRIES - 1)) ? '0 : issue_idx + 1'b1;
      rsp_valid_o <= fill_ok;
      if (fill_ok) begin
        rsp_id_o   <= id_q[fill_idx_i];
        rsp_data_o <= fill_data_i;
      end
    end
  end

  // Entry payload; only meaningful while the entry is busy, so no reset.
  always_ff @(posedge clk_i) begin
    if (do_alloc) begin
      line_q[free_idx]  <= alloc_line;
      id_q[free_idx]    <= alloc_id_i;
      we_q[free_idx]    <= alloc_we_i;
      wdata_q[free_idx] <= alloc_wdata_i;
      be_q[free_idx]    <= alloc_be_i;
    end else if (do_merge) begin
      for (int k = 0; k < BE_W; k++)
        if (alloc_be_i[k]) wdata_q[match_idx][8*k +: 8] <= alloc_wdata_i[8*k +: 8];
      be_q[match_idx] <= be_q[match_idx] | alloc_be_i;
    end
  end

endmodule

// File: tb/tb_dcache_mshr_file.sv
// tb_dcache_mshr_file
//   Directed, table-driven bench for dcache_mshr_file (default parameters).
//   Each step drives one cycle of inputs, compares outputs at the falling
//   edge, then lets the rising edge commit.
module tb_dcache_mshr_file;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alloc_valid_i, alloc_ready_o, alloc_we_i;
  logic [33:0] alloc_addr_i, lookup_addr_i, miss_addr_o;
  logic [1:0]  alloc_id_i, alloc_idx_o, miss_idx_o, fill_idx_i, rsp_id_o;
  logic [63:0] alloc_wdata_i, miss_wdata_o, fill_data_i, rsp_data_o;
  logic [7:0]  alloc_be_i, miss_be_o;
  logic        lookup_hit_o, miss_valid_o, miss_ready_i, miss_we_o;
  logic        fill_valid_i, rsp_valid_o, full_o, empty_o;

  always #5 clk_i = ~clk_i;

  dcache_mshr_file dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_addr_i(alloc_addr_i), .alloc_id_i(alloc_id_i), .alloc_we_i(alloc_we_i),
    .alloc_wdata_i(alloc_wdata_i), .alloc_be_i(alloc_be_i), .alloc_idx_o(alloc_idx_o),
    .lookup_addr_i(lookup_addr_i), .lookup_hit_o(lookup_hit_o),
    .miss_valid_o(miss_valid_o), .miss_ready_i(miss_ready_i), .miss_idx_o(miss_idx_o),
    .miss_addr_o(miss_addr_o), .miss_we_o(miss_we_o), .miss_wdata_o(miss_wdata_o),
    .miss_be_o(miss_be_o),
    .fill_valid_i(fill_valid_i), .fill_idx_i(fill_idx_i), .fill_data_i(fill_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
    .full_o(full_o), .empty_o(empty_o)
  );

  typedef struct {
    logic        rst, av, awe, mr, fv;
    logic [33:0] aaddr, laddr;
    logic [1:0]  aid, fidx;
    logic [63:0] awdata, fdata;
    logic [7:0]  abe;
  } stim_t;

  typedef struct {
    logic        er, emv, emwe, erv, efull, eempty, ehit;
    logic [1:0]  eidx, emidx, erid;
    logic [33:0] emaddr;
    logic [7:0]  embe;
    logic [15:0] emwlo;
    logic [63:0] erdata;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  int   tests_run    = 0;
  int   tests_failed = 0;
  int   step_num     = 0;
  vec_t vecs[$];

  function automatic stim_t S(longint rst, longint av, longint awe, longint aaddr,
                              longint aid, longint awdata, longint abe, longint mr,
                              longint fv, longint fidx, longint fdata, longint laddr);
    stim_t s;
    s.rst = 1'(rst);  s.av = 1'(av);   s.awe = 1'(awe);  s.aaddr = 34'(aaddr);
    s.aid = 2'(aid);  s.awdata = 64'(awdata); s.abe = 8'(abe); s.mr = 1'(mr);
    s.fv = 1'(fv);    s.fidx = 2'(fidx); s.fdata = 64'(fdata); s.laddr = 34'(laddr);
    return s;
  endfunction

  function automatic exp_t E(longint er, longint eidx, longint emv, longint emidx,
                             longint emaddr, longint emwe, longint embe, longint emwlo,
                             longint erv, longint erid, longint erdata,
                             longint efull, longint eempty, longint ehit);
    exp_t e;
    e.er = 1'(er);     e.eidx = 2'(eidx);   e.emv = 1'(emv);   e.emidx = 2'(emidx);
    e.emaddr = 34'(emaddr); e.emwe = 1'(emwe); e.embe = 8'(embe); e.emwlo = 16'(emwlo);
    e.erv = 1'(erv);   e.erid = 2'(erid);   e.erdata = 64'(erdata);
    e.efull = 1'(efull); e.eempty = 1'(eempty); e.ehit = 1'(ehit);
    return e;
  endfunction

  function automatic vec_t row(stim_t s, exp_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    return v;
  endfunction

  task automatic cmp(input string what, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL step %0d %s: got %0h, expected %0h", step_num, what, got, want);
    end
  endtask

  task automatic applyStimulus(input stim_t s);
    rst_i         = s.rst;
    alloc_valid_i = s.av;
    alloc_we_i    = s.awe;
    alloc_addr_i  = s.aaddr;
    alloc_id_i    = s.aid;
    alloc_wdata_i = s.awdata;
    alloc_be_i    = s.abe;
    miss_ready_i  = s.mr;
    fill_valid_i  = s.fv;
    fill_idx_i    = s.fidx;
    fill_data_i   = s.fdata;
    lookup_addr_i = s.laddr;
  endtask

  // Fields that are only meaningful under a valid are compared only then.
  task automatic checkOutput(input stim_t s, input exp_t e);
    if (s.av) cmp("alloc_ready", 64'(alloc_ready_o), 64'(e.er));
    if (s.rst) return;
    if (s.av && e.er) cmp("alloc_idx", 64'(alloc_idx_o), 64'(e.eidx));
    cmp("miss_valid", 64'(miss_valid_o), 64'(e.emv));
    if (e.emv) begin
      cmp("miss_idx",   64'(miss_idx_o),         64'(e.emidx));
      cmp("miss_addr",  64'(miss_addr_o),        64'(e.emaddr));
      cmp("miss_we",    64'(miss_we_o),          64'(e.emwe));
      cmp("miss_be",    64'(miss_be_o),          64'(e.embe));
      cmp("miss_wdata", 64'(miss_wdata_o[15:0]), 64'(e.emwlo));
    end
    cmp("rsp_valid", 64'(rsp_valid_o), 64'(e.erv));
    if (e.erv) begin
      cmp("rsp_id",   64'(rsp_id_o), 64'(e.erid));
      cmp("rsp_data", rsp_data_o,    e.erdata);
    end
    cmp("full",       64'(full_o),       64'(e.efull));
    cmp("empty",      64'(empty_o),      64'(e.eempty));
    cmp("lookup_hit", 64'(lookup_hit_o), 64'(e.ehit));
  endtask

  task automatic step(input stim_t s, input exp_t e);
    applyStimulus(s);
    @(negedge clk_i);
    checkOutput(s, e);
    @(posedge clk_i);
    #1;
    step_num++;
  endtask

  localparam exp_t E_RST = '{default: '0};

  initial begin
    // Basic load miss, fill and response
    vecs.push_back(row(S(0,1,0,34'h1_0000_0008,2,0,0,0,0,0,0,0),         E(1,0,0,0,0,0,0,0,0,0,0,0,1,0)));
    vecs.push_back(row(S(0,0,0,0,0,0,0,1,0,0,0,34'h1_0000_000F),         E(0,0,1,0,34'h1_0000_0008,0,0,0,0,0,0,0,0,1)));
    vecs.push_back(row(S(0,0,0,0,0,0,0,0,1,0,64'hDEAD_BEEF_CAFE_F00D,34'h1_0000_000F), E(0,0,0,0,0,0,0,0,0,0,0,0,0,1)));
    vecs.push_back(row(S(0,0,0,0,0,0,0,0,0,0,0,34'h1_0000_000F),         E(0,0,0,0,0,0,0,0,1,2,64'hDEAD_BEEF_CAFE_F00D,0,1,0)));
    vecs.push_back(row(S(0,0,0,0,0,0,0,0,0,0,0,0),                       E(0,0,0,0,0,0,0,0,0,0,0,0,1,0)));
    // Store merge while the entry waits, released as one request
    vecs.push_back(row(S(0,1,1,34'h100,1,64'h11,8'h01,0,0,0,0,0),        E(1,0,0,0,0,0,0,0,0,0,0,0,1,0)));
    vecs.push_back(row(S(0,1,1,34'h105,3,64'h2200,8'h02,0,0,0,0,0),      E(1,0,1,0,34'h100,1,8'h01,16'h0011,0,0,0,0,0,0)));
    vecs.push_back(row(S(0,0,0,0,0,0,0,1,0,0,0,0),                       E(0,0,1,0,34'h100,1,8'h03,16'h2211,0,0,0,0,0,0)));
    // Store to an INFLIGHT line stalls until the fill frees it
    vecs.push_back(row(S(0,1,1,34'h100,2,64'h33_0000,8'h04,0,0,0,0,34'h100), E(0,0,0,0,0,0,0,0,0,0,0,0,0,1)));
    vecs.push_back(row(S(0,1,1,34'h100,2,64'h33_0000,8'h04,0,1,0,64'h1234,34'h100), E(0,0,0,0,0,0,0,0,0,0,0,0,0,1)));
    vecs.push_back(row(S(0,1,1,34'h100,2,64'h33_0000,8'h04,0,0,0,0,34'h100), E(1,0,0,0,0,0,0,0,1,1,64'h1234,0,1,0)));
    // Load to a PENDING line stalls; store to an entry issuing now stalls
    vecs.push_back(row(S(0,1,0,34'h102,0,0,0,0,0,0,0,0),                 E(0,0,1,0,34'h100,1,8'h04,16'h0000,0,0,0,0,0,0)));
    vecs.push_back(row(S(0,1,1,34'h100,1,64'h77,8'h01,1,0,0,0,0),        E(0,0,1,0,34'h100,1,8'h04,16'h0000,0,0,0,0,0,0)));
    vecs.push_back(row(S(0,0,0,0,0,0,0,0,1,0,64'h55,0),                  E(0,0,0,0,0,0,0,0,0,0,0,0,0,0)));
    // Fill to an IDLE index produces nothing
    vecs.push_back(row(S(0,0,0,0,0,0,0,0,1,3,64'h99,0),                  E(0,0,0,0,0,0,0,0,1,2,64'h55,0,1,0)));
    vecs.push_back(row(S(0,0,0,0,0,0,0,0,0,0,0,0),                       E(0,0,0,0,0,0,0,0,0,0,0,0,1,0)));

    // Reset with a request presented: never accepted during reset
    step(S(1,1,1,34'h8000,0,0,8'hFF,0,0,0,0,0), E_RST);
    step(S(1,1,1,34'h8000,0,0,8'hFF,0,0,0,0,0), E_RST);

    foreach (vecs[i]) step(vecs[i].s, vecs[i].e);

    // Full, round-robin issue and fill/alloc timing, from a clean reset
    step(S(1,0,0,0,0,0,0,0,0,0,0,0), E_RST);
    for (int k = 0; k < 4; k++)
      step(S(0,1,0,34'h1000*(k+1),k,0,0,0,0,0,0,0),
           E(1,k,(k>0)?1:0,0,34'h1000,0,0,0,0,0,0,0,(k==0)?1:0,0));
    for (int k = 0; k < 4; k++)
      step(S(0,1,0,34'h5000,0,0,0,1,0,0,0,0),
           E(0,0,1,k,34'h1000*(k+1),0,0,0,0,0,0,1,0,0));
    step(S(0,1,0,34'h5000,0,0,0,1,1,2,64'hA2,0), E(0,0,0,0,0,0,0,0,0,0,0,1,0,0));
    step(S(0,1,0,34'h5000,0,0,0,0,0,0,0,0),      E(1,2,0,0,0,0,0,0,1,2,64'hA2,0,0,0));
    step(S(0,0,0,0,0,0,0,0,1,0,64'hA0,0),        E(0,0,1,2,34'h5000,0,0,0,0,0,0,1,0,0));
    step(S(0,0,0,0,0,0,0,0,1,1,64'hA1,0),        E(0,0,1,2,34'h5000,0,0,0,1,0,64'hA0,0,0,0));
    step(S(0,1,0,34'h6000,1,0,0,0,0,0,0,0),      E(1,0,1,2,34'h5000,0,0,0,1,1,64'hA1,0,0,0));
    step(S(0,1,0,34'h7000,3,0,0,0,0,0,0,0),      E(1,1,1,0,34'h6000,0,0,0,0,0,0,0,0,0));
    step(S(0,0,0,0,0,0,0,1,0,0,0,0),             E(0,0,1,0,34'h6000,0,0,0,0,0,0,1,0,0));
    step(S(0,0,0,0,0,0,0,1,0,0,0,0),             E(0,0,1,1,34'h7000,0,0,0,0,0,0,1,0,0));
    step(S(0,0,0,0,0,0,0,1,0,0,0,0),             E(0,0,1,2,34'h5000,0,0,0,0,0,0,1,0,0));
    step(S(0,0,0,0,0,0,0,1,1,3,64'hA3,0),        E(0,0,0,0,0,0,0,0,0,0,0,1,0,0));
    step(S(0,0,0,0,0,0,0,0,0,0,0,0),             E(0,0,0,0,0,0,0,0,1,3,64'hA3,0,0,0));

    // Reset with three entries INFLIGHT: everything discarded
    step(S(1,1,0,34'h8000,0,0,0,0,1,0,64'hB0,0), E_RST);
    step(S(0,0,0,0,0,0,0,0,1,1,64'hB1,0),        E(0,0,0,0,0,0,0,0,0,0,0,0,1,0));
    cmp("rsp_id_after_reset",   64'(rsp_id_o), 64'h0);
    cmp("rsp_data_after_reset", rsp_data_o,    64'h0);
    step(S(0,0,0,0,0,0,0,0,0,0,0,0),             E(0,0,0,0,0,0,0,0,0,0,0,0,1,0));
    step(S(0,1,1,34'h9000,1,64'hFF,8'hFF,0,0,0,0,0), E(1,0,0,0,0,0,0,0,0,0,0,0,1,0));
    step(S(0,0,0,0,0,0,0,0,0,0,0,0),             E(0,0,1,0,34'h9000,1,8'hFF,16'h00FF,0,0,0,0,0,0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
